// File: rtl/dmem_arbiter_if.sv
// Bus bundle around dmem_arbiter: CPU (MEM stage) port, loader port, data_memory port.
// slave = the arbiter's view; master = the environment (CPU, loader and memory).
interface dmem_arbiter_if;
  logic        cpu_MemRead;
  logic        cpu_MemWrite;
  logic [31:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;

  // Loader handshake: a transfer happens on a posedge where ldr_valid & ldr_ready;
  // ldr_valid and its fields stay stable until then, ldr_ready never waits on anything
  // but arbitration, and read data returns one cycle later with a one-cycle ldr_rvalid.
  logic        ldr_valid;
  logic        ldr_write;
  logic [31:0] ldr_address;
  logic [31:0] ldr_write_data;
  logic        ldr_ready;
  logic [31:0] ldr_read_data;
  logic        ldr_rvalid;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic        err;
  logic [31:0] err_address;
  logic [3:0]  streak;

  modport slave (
    input  cpu_MemRead, cpu_MemWrite, cpu_address, cpu_write_data,
    output cpu_read_data, cpu_stall,
    input  ldr_valid, ldr_write, ldr_address, ldr_write_data,
    output ldr_ready, ldr_read_data, ldr_rvalid,
    output MemRead, MemWrite, address, write_data,
    input  read_data,
    output err, err_address, streak
  );

  modport master (
    output cpu_MemRead, cpu_MemWrite, cpu_address, cpu_write_data,
    input  cpu_read_data, cpu_stall,
    output ldr_valid, ldr_write, ldr_address, ldr_write_data,
    input  ldr_ready, ldr_read_data, ldr_rvalid,
    input  MemRead, MemWrite, address, write_data,
    output read_data,
    input  err, err_address, streak
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority with a starvation guard for the loader,
// access-error screening, and a registered loader read-return path.
module dmem_arbiter #(
  parameter int SIZE       = 64,
  parameter int MAX_STREAK = 4
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [31:0] SIZE_W     = 32'(SIZE);

  logic [3:0]  streak_q;
  logic        err_q;
  logic [31:0] err_addr_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic        cpu_req;
  logic        grant_cpu;
  logic        grant_ldr;
  logic        sel_rd;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic        acc_err;

  always_comb begin
    cpu_req   = bus.cpu_MemRead | bus.cpu_MemWrite;
    // Loader wins when alone, or when the CPU has used up its streak allowance.
    grant_ldr = bus.ldr_valid & (~cpu_req | (streak_q == STREAK_MAX));
    grant_cpu = cpu_req & ~grant_ldr;

    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (grant_ldr) begin
      sel_rd   = ~bus.ldr_write;
      sel_wr   = bus.ldr_write;
      sel_addr = bus.ldr_address;
      sel_data = bus.ldr_write_data;
    end else if (grant_cpu) begin
      sel_rd   = bus.cpu_MemRead;
      sel_wr   = bus.cpu_MemWrite;
      sel_addr = bus.cpu_address;
      sel_data = bus.cpu_write_data;
    end

    acc_err = (grant_cpu | grant_ldr) &
              ((sel_addr[1:0] != 2'b00) | ({2'b00, sel_addr[31:2]} >= SIZE_W));
  end

  assign bus.MemRead    = sel_rd;
  assign bus.MemWrite   = sel_wr & ~acc_err;
  assign bus.address    = sel_addr;
  assign bus.write_data = sel_data;

  // Read+write together returns the pre-write word: the memory read is combinational.
  assign bus.cpu_read_data = (grant_cpu & bus.cpu_MemRead & ~acc_err) ? bus.read_data : '0;
  assign bus.cpu_stall     = cpu_req & grant_ldr;
  assign bus.ldr_ready     = grant_ldr;

  assign bus.ldr_rvalid    = rvalid_q;
  assign bus.ldr_read_data = rdata_q;
  assign bus.err           = err_q;
  assign bus.err_address   = err_addr_q;
  assign bus.streak        = streak_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (grant_cpu & bus.ldr_valid) begin
        if (streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
      end else begin
        streak_q <= '0;
      end

      rvalid_q <= grant_ldr & ~bus.ldr_write;
      if (grant_ldr & ~bus.ldr_write) rdata_q <= acc_err ? '0 : bus.read_data;

      if (acc_err & ~err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= sel_addr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector table plus hand-written corner sequences for dmem_arbiter; loader read returns
// are checked through an expected-data queue.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if dif ();

  dmem_arbiter #(.SIZE(64), .MAX_STREAK(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  // Stand-in for data_memory: combinational read, write at posedge.
  logic [31:0] mem [64] = '{default: '0};
  assign dif.read_data = mem[dif.address[7:2]];
  always @(posedge clk) if (dif.MemWrite) mem[dif.address[7:2]] <= dif.write_data;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lv, lw;
    logic [31:0] la, ld;
    logic        e_stall, e_ready, e_mr, e_mw;
    logic [31:0] e_addr, e_crd, e_lrd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        rv_due  = 1'b0;

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic lv, logic lw, logic [31:0] la, logic [31:0] ld,
                              logic es, logic er, logic emr, logic emw,
                              logic [31:0] ea, logic [31:0] ecrd, logic [31:0] elrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lv = lv; v.lw = lw; v.la = la; v.ld = ld;
    v.e_stall = es; v.e_ready = er; v.e_mr = emr; v.e_mw = emw;
    v.e_addr = ea; v.e_crd = ecrd; v.e_lrd = elrd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dif.cpu_MemRead    = v.cr;
    dif.cpu_MemWrite   = v.cw;
    dif.cpu_address    = v.ca;
    dif.cpu_write_data = v.cd;
    dif.ldr_valid      = v.lv;
    dif.ldr_write      = v.lw;
    dif.ldr_address    = v.la;
    dif.ldr_write_data = v.ld;
  endtask

  // Drive at negedge, compare just after; the read return from the previous edge is
  // popped from exp_q before this cycle's expected acceptance is pushed.
  task automatic apply(input vec_t v, input int idx);
    logic [31:0] e;
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("row%0d_rvalid", idx), {31'b0, dif.ldr_rvalid}, {31'b0, rv_due});
    if (rv_due) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL row%0d_queue: got empty expected entry", idx);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("row%0d_ldr_rdata", idx), dif.ldr_read_data, e);
      end
    end
    rv_due = v.lv & ~v.lw & v.e_ready;
    if (rv_due) exp_q.push_back(v.e_lrd);
    check($sformatf("row%0d_stall", idx),   {31'b0, dif.cpu_stall}, {31'b0, v.e_stall});
    check($sformatf("row%0d_ready", idx),   {31'b0, dif.ldr_ready}, {31'b0, v.e_ready});
    check($sformatf("row%0d_memread", idx), {31'b0, dif.MemRead},   {31'b0, v.e_mr});
    check($sformatf("row%0d_memwrite", idx),{31'b0, dif.MemWrite},  {31'b0, v.e_mw});
    check($sformatf("row%0d_address", idx), dif.address,           v.e_addr);
    check($sformatf("row%0d_cpu_rdata", idx), dif.cpu_read_data,    v.e_crd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0);

    // CPU-only, loader-only, back-to-back loader reads, CPU read+write
    vecs.push_back(mk(0,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,0,1, 32'h10,0,0));
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0, 0,0,1,0, 32'h10,32'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h20,32'h12345678, 0,1,0,1, 32'h20,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h20,0, 0,1,1,0, 32'h20,0,32'h12345678));
    vecs.push_back(idle);
    vecs.push_back(mk(0,0,0,0, 1,0,32'h10,0, 0,1,1,0, 32'h10,0,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h20,0, 0,1,1,0, 32'h20,0,32'h12345678));
    vecs.push_back(idle);
    vecs.push_back(mk(1,1,32'h10,32'hA5A5A5A5, 0,0,0,0, 0,0,1,1, 32'h10,32'hDEADBEEF,0));
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0, 0,0,1,0, 32'h10,32'hA5A5A5A5,0));
    // Contention: CPU x4 then loader, twice
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h20,0, 1,1,32'h30,32'h0BADF00D, 0,0,1,0, 32'h20,32'h12345678,0));
    vecs.push_back(mk(1,0,32'h20,0, 1,1,32'h30,32'h0BADF00D, 1,1,0,1, 32'h30,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h20,0, 1,1,32'h34,32'hCAFEF00D, 0,0,1,0, 32'h20,32'h12345678,0));
    vecs.push_back(mk(1,0,32'h20,0, 1,1,32'h34,32'hCAFEF00D, 1,1,0,1, 32'h34,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h30,0, 0,1,1,0, 32'h30,0,32'h0BADF00D));
    vecs.push_back(mk(1,0,32'h34,0, 0,0,0,0, 0,0,1,0, 32'h34,32'hCAFEF00D,0));
    // Loader wins against a CPU write to the same word: reads old value, CPU retries
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h40,0, 1,0,32'h40,0, 0,0,1,0, 32'h40,0,0));
    vecs.push_back(mk(0,1,32'h40,32'h77777777, 1,0,32'h40,0, 1,1,1,0, 32'h40,0,0));
    vecs.push_back(mk(0,1,32'h40,32'h77777777, 0,0,0,0, 0,0,0,1, 32'h40,0,0));
    vecs.push_back(mk(1,0,32'h40,0, 0,0,0,0, 0,0,1,0, 32'h40,32'h77777777,0));
    // Errors: misaligned CPU write, out-of-range loader write, erroring reads
    vecs.push_back(mk(0,1,32'h13,32'hFFFFFFFF, 0,0,0,0, 0,0,0,0, 32'h13,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h100,32'hEEEEEEEE, 0,1,0,0, 32'h100,0,0));
    vecs.push_back(mk(1,0,32'h13,0, 0,0,0,0, 0,0,1,0, 32'h13,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h100,0, 0,1,1,0, 32'h100,0,0));
    vecs.push_back(idle);

    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_err",        {31'b0, dif.err},        32'h0);
    check("reset_err_addr",   dif.err_address,          32'h0);
    check("reset_rvalid",     {31'b0, dif.ldr_rvalid}, 32'h0);
    check("reset_ldr_rdata",  dif.ldr_read_data,        32'h0);
    check("reset_streak",     {28'b0, dif.streak},      32'h0);
    check("reset_idle_addr",  dif.address,              32'h0);
    check("reset_idle_mw",    {31'b0, dif.MemWrite},    32'h0);

    foreach (vecs[i]) apply(vecs[i], i);

    check("err_flag",        {31'b0, dif.err}, 32'h1);
    check("err_first_addr",  dif.err_address,  32'h13);
    check("mem_misaligned_untouched", mem[4], 32'hA5A5A5A5);
    check("mem_range_untouched",      mem[0], 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    // Reset one cycle after a loader read is accepted
    @(negedge clk);
    drive(mk(0,0,0,0, 1,0,32'h20,0, 0,0,0,0, 0,0,0));
    #1;
    check("rst_seq_accept", {31'b0, dif.ldr_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(1,0,32'h10,0, 1,0,32'h10,0, 0,0,0,0, 0,0,0));
    #1;
    check("rst_seq_rvalid_pre", {31'b0, dif.ldr_rvalid}, 32'h1);
    check("rst_seq_rdata_pre",  dif.ldr_read_data,        32'h12345678);
    check("rst_seq_stall_pre",  {31'b0, dif.cpu_stall},  32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    #1;
    check("rst_seq_rvalid",   {31'b0, dif.ldr_rvalid}, 32'h0);
    check("rst_seq_streak",   {28'b0, dif.streak},      32'h0);
    check("rst_seq_err",      {31'b0, dif.err},         32'h0);
    check("rst_seq_err_addr", dif.err_address,          32'h0);
    check("rst_seq_rdata",    dif.ldr_read_data,        32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port `data_memory` between the pipeline MEM stage (CPU port) and a testbench/boot loader port (LDR port), one word access per cycle. The CPU has priority, with a starvation guard that forces a loader grant after a programmable run of consecutive CPU accesses. It stalls the pipeline when the CPU loses arbitration, and it flags misaligned or out-of-range accesses. The block sits between the MEM stage, the loader and the `data_memory` instance inside the pipeline top level.

## Interface
Parameters:
- `SIZE`, 64: memory depth in words. Must match the `data_memory` `size`.
- `MAX_STREAK`, 4: number of consecutive CPU grants allowed while the loader waits. Range 1..15.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `cpu_MemRead`  in  1: CPU read request.
- `cpu_MemWrite`  in  1: CPU write request.
- `cpu_address`  in  32: CPU byte address.
- `cpu_write_data`  in  32: CPU store data.
- `cpu_read_data`  out  32: CPU load data, combinational.
- `cpu_stall`  out  1: holds the pipeline because the CPU access was not granted this cycle.
- `ldr_valid`  in  1: loader request valid.
- `ldr_write`  in  1: 1 = write, 0 = read. Qualified by `ldr_valid`.
- `ldr_address`  in  32: loader byte address.
- `ldr_write_data`  in  32: loader store data.
- `ldr_ready`  out  1: loader request accepted this cycle.
- `ldr_read_data`  out  32: registered loader read data.
- `ldr_rvalid`  out  1: `ldr_read_data` is valid (one-cycle pulse).
- `MemRead`  out  1: to `data_memory`.
- `MemWrite`  out  1: to `data_memory`.
- `address`  out  32: to `data_memory`.
- `write_data`  out  32: to `data_memory`.
- `read_data`  in  32: from `data_memory`. Combinational read; write happens at posedge.
- `err`  out  1: sticky access-error flag.
- `err_address`  out  32: byte address of the first error.

## Operation
- A CPU request means `cpu_MemRead | cpu_MemWrite`. A loader request means `ldr_valid`.
- Arbitration is evaluated combinationally every cycle from the registered `streak` counter (4 bits):
  - Only one side requesting: that side is granted.
  - Both requesting and `streak < MAX_STREAK`: CPU is granted.
  - Both requesting and `streak == MAX_STREAK`: loader is granted.
  - Neither requesting: memory controls are driven 0 and `address` is driven 0.
- `streak` update at posedge:
  - CPU granted while `ldr_valid`=1: increment, saturating at `MAX_STREAK`.
  - Loader granted, or `ldr_valid`=0: clear to 0.
- CPU granted: memory ports mirror the CPU inputs. `cpu_read_data` = `read_data` when `cpu_MemRead`, else 0. `cpu_stall`=0.
- Loader granted: `MemRead`=~`ldr_write`, `MemWrite`=`ldr_write`, and address/data come from the loader. `ldr_ready`=1. `cpu_stall` equals the CPU request; `cpu_read_data`=0.
- Loader read: `ldr_read_data` is registered from `read_data` at the accepting edge. `ldr_rvalid`=1 for the following cycle; otherwise `ldr_rvalid`=0 and `ldr_read_data` holds its value.
- Error checks apply to the granted access:
  - The access is an error if `address[1:0]`≠0 or `address>>2` ≥ `SIZE`.
  - An erroring write is suppressed (`MemWrite` forced 0). An erroring read returns 0.
  - The handshake still completes (`ldr_ready` / no stall) so requesters never hang.
  - On the first error, `err` sets and `err_address` latches the address. Both hold until reset.
- If the CPU asserts both `MemRead` and `MemWrite`, it is treated as a write; the read data returned is the pre-write memory content.

## Timing
- Reset values: `streak`=0, `err`=0, `err_address`=0, `ldr_rvalid`=0, `ldr_read_data`=0. All combinational outputs follow the inputs from the first cycle after reset.
- CPU access latency: reads are zero-cycle (same-cycle data). Writes land at the granting posedge.
- Loader access latency: read data is available one cycle after the `ldr_valid & ldr_ready` edge. Writes land at the accepting edge.
- Loader protocol: `ldr_valid` and its fields must stay stable until `ldr_ready`. Back-to-back loader transfers are allowed at 1 per cycle.
- Worst-case loader wait under continuous CPU traffic is `MAX_STREAK`+1 cycles. A CPU stall lasts exactly one cycle per loader grant.
- Reset asserted mid-transfer: `ldr_rvalid` is cleared on the next edge and the pending read is dropped. The memory write at that edge still occurs if it is granted that cycle.

## Test plan
- CPU only: write 0xDEADBEEF to addr 0x10, then read addr 0x10 → `cpu_read_data`=0xDEADBEEF in the same cycle, `cpu_stall`=0 throughout.
- Loader only: write 0x12345678 to addr 0x20, then read 0x20 → `ldr_ready`=1 on both cycles; `ldr_rvalid`=1 and `ldr_read_data`=0x12345678 one cycle after the read.
- Contention with `MAX_STREAK`=4: CPU requests every cycle while the loader holds a request → grants CPU,CPU,CPU,CPU,LDR, repeating. `cpu_stall`=1 only on the 5th cycle of each group.
- Error handling: CPU write to 0x13, then loader write to 0x100 with `SIZE`=64 → memory unchanged, `err`=1, `err_address`=0x13 (held after the second error), no hang.
- Reset mid-read: loader read accepted, reset asserted on the next cycle → `ldr_rvalid`=0, `streak`=0, `err`=0 after the edge.
- Simultaneous CPU write and loader read of the same word while the loader wins → loader reads the old value; the CPU write completes the next cycle after its stall.
